decode_job_ctl: RTL and testbench

- Job sequencer in front of the LZS decode engine (bit-stream input stage plus token controller).
- Accepts one decode job at a time, holds the engine in reset between jobs, then enables it.
- Counts decoded output bytes until the engine signals end of stream, and reports per-job completion status.
- Detects length overrun, stalls (watchdog timeout) and host abort.

---
 rtl/decode_job_ctl.sv | 148 ++++++++++++++
 tb/tb_decode_job_ctl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_job_ctl.sv
// Job sequencer for the LZS decode engine: holds the engine in reset between jobs,
// runs it, counts output bytes and reports completion status (ok/overrun/timeout/abort).
module decode_job_ctl #(
   parameter int ID_W    = 4,
   parameter int LEN_W   = 16,
   parameter int RST_CYC = 2,
   parameter int TMO_W   = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [ID_W-1:0]  job_id,
   input  logic [LEN_W-1:0] job_len,
   input  logic             abort,
   output logic             eng_rst,
   output logic             eng_ce,
   input  logic             fo_full,
   input  logic             out_valid,
   input  logic             out_end,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [ID_W-1:0]  done_id,
   output logic [LEN_W-1:0] done_cnt,
   output logic [1:0]       done_err
);

   localparam int CLR_W = $clog2(RST_CYC + 1);
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RST_CYC - 1);

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_LEN   = 2'd1;
   localparam logic [1:0] ERR_TMO   = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [ID_W-1:0]  id_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q, cnt_nx, cnt_inc;
   logic [TMO_W-1:0] wd_q, wd_nx;
   logic [CLR_W-1:0] clr_q, clr_nx;
   logic             accept, term, byte_ok;
   logic [1:0]       err_nx;
   logic [LEN_W-1:0] fin_cnt;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt_q;
      wd_nx    = wd_q;
      clr_nx   = clr_q;
      accept   = 1'b0;
      term     = 1'b0;
      err_nx   = ERR_OK;
      fin_cnt  = cnt_q;
      // a byte beyond job_len is never counted, so the count cannot wrap
      byte_ok  = out_valid && (cnt_q != len_q);
      cnt_inc  = cnt_q + LEN_W'(byte_ok);

      case (state)
         IDLE: begin
            if (job_valid) begin
               accept   = 1'b1;
               state_nx = CLR;
               cnt_nx   = '0;
               wd_nx    = '0;
               clr_nx   = '0;
            end
         end
         CLR: begin
            if (abort) begin
               term    = 1'b1;
               err_nx  = ERR_ABORT;
               fin_cnt = '0;
            end else if (clr_q == CLR_LAST) begin
               state_nx = RUN;
            end else begin
               clr_nx = clr_q + CLR_W'(1);
            end
         end
         RUN: begin
            cnt_nx  = cnt_inc;
            fin_cnt = cnt_inc;
            // backpressure from a full FIFO is not a stall
            wd_nx   = (out_valid || fo_full) ? '0 : wd_q + TMO_W'(1);
            if (abort) begin
               term   = 1'b1;
               err_nx = ERR_ABORT;
            end else if (out_end) begin
               term   = 1'b1;
               err_nx = (cnt_inc == len_q) ? ERR_OK : ERR_LEN;
            end else if (out_valid && (cnt_q == len_q)) begin
               term   = 1'b1;
               err_nx = ERR_LEN;
            end else if (wd_nx == '1) begin
               term   = 1'b1;
               err_nx = ERR_TMO;
            end
         end
         DONE: begin
            if (done_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (term) state_nx = DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         id_q       <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         wd_q       <= '0;
         clr_q      <= '0;
         job_ready  <= 1'b1;
         eng_rst    <= 1'b1;
         eng_ce     <= 1'b0;
         done_valid <= 1'b0;
         done_id    <= '0;
         done_cnt   <= '0;
         done_err   <= '0;
      end else begin
         state     <= state_nx;
         cnt_q     <= cnt_nx;
         wd_q      <= wd_nx;
         clr_q     <= clr_nx;
         job_ready <= (state_nx == IDLE);
         eng_rst   <= (state_nx != RUN);
         eng_ce    <= (state_nx == RUN);
         if (accept) begin
            id_q  <= job_id;
            len_q <= job_len;
         end
         if (term) begin
            done_valid <= 1'b1;
            done_id    <= id_q;
            done_cnt   <= fin_cnt;
            done_err   <= err_nx;
         end else if ((state == DONE) && done_ready) begin
            done_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_job_ctl.sv
// Directed bench for decode_job_ctl: stimulus pushes expected status records,
// a negedge monitor pops and compares them on each status handshake.
module tb_decode_job_ctl;

   localparam int ID_W    = 4;
   localparam int LEN_W   = 16;
   localparam int RST_CYC = 2;
   localparam int TMO_W   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             job_valid = 1'b0;
   logic             job_ready;
   logic [ID_W-1:0]  job_id = '0;
   logic [LEN_W-1:0] job_len = '0;
   logic             abort = 1'b0;
   logic             eng_rst, eng_ce;
   logic             fo_full = 1'b0;
   logic             out_valid = 1'b0;
   logic             out_end = 1'b0;
   logic             done_valid;
   logic             done_ready = 1'b1;
   logic [ID_W-1:0]  done_id;
   logic [LEN_W-1:0] done_cnt;
   logic [1:0]       done_err;

   decode_job_ctl #(.ID_W(ID_W), .LEN_W(LEN_W), .RST_CYC(RST_CYC), .TMO_W(TMO_W)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id), .job_len(job_len),
      .abort(abort), .eng_rst(eng_rst), .eng_ce(eng_ce), .fo_full(fo_full),
      .out_valid(out_valid), .out_end(out_end),
      .done_valid(done_valid), .done_ready(done_ready),
      .done_id(done_id), .done_cnt(done_cnt), .done_err(done_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [LEN_W-1:0] cnt;
      logic [1:0]       err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done_valid && done_ready) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_status: got id=%0d cnt=%0d err=%0d, required none",
                     done_id, done_cnt, done_err);
         end else begin
            e = exp_q.pop_front();
            chk("done_id",  32'(done_id),  32'(e.id));
            chk("done_cnt", 32'(done_cnt), 32'(e.cnt));
            chk("done_err", 32'(done_err), 32'(e.err));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int id, input int cnt, input int err);
      exp_t e;
      e.id  = ID_W'(id);
      e.cnt = LEN_W'(cnt);
      e.err = 2'(err);
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (!job_ready && k < budget) begin
         step();
         k++;
      end
      chk("idle_wait", 32'(job_ready), 1);
   endtask

   // accept a job; when run_chk is set, also verify the CLR -> RUN timing
   task automatic submit(input int id, input int len, input bit run_chk);
      wait_idle(50);
      job_id    = ID_W'(id);
      job_len   = LEN_W'(len);
      job_valid = 1'b1;
      step();
      job_valid = 1'b0;
      chk("clr_eng_rst",   32'(eng_rst),   1);
      chk("clr_job_ready", 32'(job_ready), 0);
      if (run_chk) begin
         step();
         chk("clr2_eng_ce", 32'(eng_ce), 0);
         step();
         chk("run_eng_rst", 32'(eng_rst), 0);
         chk("run_eng_ce",  32'(eng_ce),  1);
      end
   endtask

   task automatic drv(input bit v, input bit e, input bit a);
      out_valid = v;
      out_end   = e;
      abort     = a;
      step();
      out_valid = 1'b0;
      out_end   = 1'b0;
      abort     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      logic seen;

      // reset values
      rst = 1'b1;
      step(3);
      chk("rst_job_ready",  32'(job_ready),  1);
      chk("rst_eng_rst",    32'(eng_rst),    1);
      chk("rst_eng_ce",     32'(eng_ce),     0);
      chk("rst_done_valid", 32'(done_valid), 0);
      chk("rst_done_flds",  32'({done_id, done_cnt, done_err}), 0);
      rst = 1'b0;
      step();

      // nominal job
      push(5, 3, 0);
      submit(5, 3, 1);
      drv(1, 0, 0); drv(1, 0, 0); drv(1, 0, 0);
      drv(0, 1, 0);
      chk("nom_done_valid", 32'(done_valid), 1);
      chk("nom_eng_rst",    32'(eng_rst),    1);
      chk("nom_eng_ce",     32'(eng_ce),     0);
      step();
      chk("nom_job_ready",  32'(job_ready),  1);
      chk("nom_done_clr",   32'(done_valid), 0);

      // end on the last byte, same cycle
      push(1, 4, 0);
      submit(1, 4, 1);
      drv(1, 0, 0); drv(1, 0, 0); drv(1, 0, 0);
      drv(1, 1, 0);
      wait_idle(10);

      // short stream
      push(2, 2, 1);
      submit(2, 4, 1);
      drv(1, 0, 0);
      drv(1, 1, 0);
      wait_idle(10);

      // overrun on the third byte
      push(3, 2, 1);
      submit(3, 2, 1);
      drv(1, 0, 0); drv(1, 0, 0); drv(1, 0, 0);
      chk("ovr_done_valid", 32'(done_valid), 1);
      chk("ovr_eng_rst",    32'(eng_rst),    1);
      wait_idle(10);

      // watchdog: fires on the 15th idle cycle in RUN
      push(4, 0, 2);
      submit(4, 1, 1);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         seen |= done_valid;
         step();
      end
      chk("tmo_not_early", 32'(seen),       0);
      chk("tmo_fired",     32'(done_valid), 1);
      wait_idle(10);

      // full FIFO is backpressure, no timeout
      push(6, 2, 0);
      submit(6, 2, 1);
      seen = 1'b0;
      step(10);
      fo_full = 1'b1;
      for (int i = 0; i < 40; i++) begin
         seen |= done_valid;
         step();
      end
      fo_full = 1'b0;
      step(10);
      chk("full_no_tmo", 32'(seen | done_valid), 0);
      drv(1, 0, 0);
      drv(1, 1, 0);
      wait_idle(10);

      // abort during CLR
      push(7, 0, 3);
      submit(7, 5, 0);
      drv(0, 0, 1);
      chk("clr_abort_done", 32'(done_valid), 1);
      wait_idle(10);

      // abort beats out_end
      push(8, 1, 3);
      submit(8, 2, 1);
      drv(1, 0, 0);
      drv(0, 1, 1);
      wait_idle(10);

      // abort in IDLE has no effect
      seen = 1'b0;
      abort = 1'b1;
      for (int i = 0; i < 5; i++) begin
         seen |= done_valid | ~job_ready | ~eng_rst;
         step();
      end
      abort = 1'b0;
      chk("idle_abort", 32'(seen), 0);

      // status held while done_ready is low; no job accepted
      done_ready = 1'b0;
      push(9, 1, 0);
      submit(9, 1, 1);
      drv(1, 1, 0);
      job_valid = 1'b1;
      job_id    = 4'd3;
      job_len   = 16'd1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         seen |= (done_valid !== 1'b1) || (done_id !== 4'd9) || (done_cnt !== 16'd1) ||
                 (done_err !== 2'd0) || (job_ready !== 1'b0);
         step();
      end
      chk("hold_stable", 32'(seen), 0);
      done_ready = 1'b1;
      job_valid  = 1'b0;
      step();
      chk("hold_release", 32'(job_ready), 1);

      // reset mid-job: no status for the killed job
      submit(10, 3, 1);
      drv(1, 0, 0);
      rst = 1'b1;
      step();
      chk("mid_rst_done_valid", 32'(done_valid), 0);
      chk("mid_rst_ctl", 32'({job_ready, eng_rst, eng_ce}), 32'(3'b110));
      chk("mid_rst_flds", 32'({done_id, done_cnt, done_err}), 0);
      rst = 1'b0;
      step(2);

      // controller usable after mid-job reset
      push(11, 1, 0);
      submit(11, 1, 1);
      drv(1, 1, 0);
      wait_idle(10);

      step(3);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
